// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave for any CPOL/CPHA mode, WIDTH-bit words sent MSB first, with valid/ready client handshakes.
// Ports: clk/rst       system clock, asynchronous active-high reset
//        sclk_in/mosi_in/ss_in  raw SPI pins from the master (asynchronous to clk)
//        miso          SPI data to the master, 0 while deselected
//        tx_data/tx_valid/tx_ready  one-deep transmit holding register
//        rx_data/rx_valid/rx_ready  received word handshake
//        rx_overrun/tx_underrun     one-cycle error pulses
//        busy          synchronised slave select is asserted
module spi_slave_param #(
    parameter int WIDTH       = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk_in,
    input  logic             mosi_in,
    input  logic             ss_in,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             tx_underrun,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sclk_prev;
    logic                   r_ss_prev;
    logic                   r_lead;
    logic                   r_trail;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_tx_shift;
    logic [WIDTH-2:0]       r_rx_shift;
    logic [WIDTH-1:0]       r_hold;
    logic                   r_hold_full;
    logic                   w_sclk;
    logic                   w_mosi;
    logic                   w_ss;
    logic                   w_sample;
    logic                   w_shift;
    logic                   w_last;
    logic                   w_start;
    logic [WIDTH-1:0]       w_rx_word;
    logic [WIDTH-1:0]       w_load;

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss      = r_ss_sync[SYNC_STAGES-1];
    assign w_sample  = CPHA ? r_trail : r_lead;
    assign w_shift   = CPHA ? r_lead : r_trail;
    assign w_last    = r_cnt == LAST;
    assign w_rx_word = {r_rx_shift, w_mosi};
    assign w_load    = r_hold_full ? r_hold : '0;
    // A word starts on SS fall, or when the previous word has run out:
    // CPHA=1 at the last sample edge, CPHA=0 at the shift edge that follows it.
    assign w_start   = (r_state == IDLE) ? (r_ss_prev && !w_ss)
                     : (!w_ss && (CPHA ? (w_sample && w_last) : (w_shift && r_cnt == '0)));
    assign tx_ready  = !r_hold_full;
    assign busy      = r_state == ACTIVE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b0;
            r_lead      <= 1'b0;
            r_trail     <= 1'b0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            miso        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_in};
            r_sclk_prev <= w_sclk;
            r_ss_prev   <= w_ss;
            // Edge flags are registered so every edge acts a fixed number of cycles after the pin.
            r_lead      <= (w_sclk != r_sclk_prev) && (w_sclk != CPOL);
            r_trail     <= (w_sclk != r_sclk_prev) && (w_sclk == CPOL);
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_start)
                    r_state <= ACTIVE;
            end else if (w_ss) begin
                r_state    <= IDLE;
                r_cnt      <= '0;
                r_rx_shift <= '0;
                miso       <= 1'b0;
            end else begin
                if (w_sample) begin
                    r_rx_shift <= w_rx_word[WIDTH-2:0];
                    r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        rx_data    <= w_rx_word;
                        rx_valid   <= 1'b1;
                        rx_overrun <= rx_valid && !rx_ready;
                    end
                end
                if (w_shift && !w_start) begin
                    miso       <= r_tx_shift[WIDTH-1];
                    r_tx_shift <= r_tx_shift << 1;
                end
            end
            // CPHA=0 drives the MSB straight away, so the shifter keeps only the remaining bits.
            if (w_start) begin
                r_tx_shift  <= CPHA ? w_load : {w_load[WIDTH-2:0], 1'b0};
                miso        <= CPHA ? miso : w_load[WIDTH-1];
                r_hold_full <= 1'b0;
                tx_underrun <= !r_hold_full;
            end
            // Placed after the load so a same-cycle accept refills the register the load just emptied.
            if (tx_valid && tx_ready) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: directed bench for spi_slave_param covering all four modes, overrun, underrun, SS abort, reset and WIDTH=12.
module tb_spi_slave_param;
    localparam int H = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk_a = 1'b0;
    logic        mosi = 1'b0;
    logic [4:0]  ss = '1;
    logic [11:0] txd = '0;
    logic [4:0]  tx_valid = '0;
    logic [4:0]  rx_ready = '0;
    logic [4:0]  miso;
    logic [4:0]  tx_ready;
    logic [4:0]  rx_valid;
    logic [4:0]  rx_ovr;
    logic [4:0]  tx_und;
    logic [4:0]  busy;
    logic [7:0]  rxd [4];
    logic [11:0] rxd12;
    logic [4:0]  rxv_q = '0;
    int          cyc = 0;
    int          last_samp = 0;
    int          rise_cyc [5];
    int          n_rise [5];
    int          n_ovr [5];
    int          n_und [5];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mi;
    int          r0;
    int          u0;
    int          o0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rxv_q <= rx_valid;
        for (int i = 0; i < 5; i++) begin
            if (rx_valid[i] && !rxv_q[i]) begin
                n_rise[i]   <= n_rise[i] + 1;
                rise_cyc[i] <= cyc;
            end
            if (rx_ovr[i])
                n_ovr[i] <= n_ovr[i] + 1;
            if (tx_und[i])
                n_und[i] <= n_und[i] + 1;
        end
    end

    spi_slave_param #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u0_dut (
        .clk(clk), .rst(rst), .sclk_in(sclk_a), .mosi_in(mosi), .ss_in(ss[0]), .miso(miso[0]),
        .tx_data(txd[7:0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .rx_data(rxd[0]),
        .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .rx_overrun(rx_ovr[0]),
        .tx_underrun(tx_und[0]), .busy(busy[0]));
    spi_slave_param #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2)) u1_dut (
        .clk(clk), .rst(rst), .sclk_in(sclk_a), .mosi_in(mosi), .ss_in(ss[1]), .miso(miso[1]),
        .tx_data(txd[7:0]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .rx_data(rxd[1]),
        .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .rx_overrun(rx_ovr[1]),
        .tx_underrun(tx_und[1]), .busy(busy[1]));
    spi_slave_param #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(2)) u2_dut (
        .clk(clk), .rst(rst), .sclk_in(~sclk_a), .mosi_in(mosi), .ss_in(ss[2]), .miso(miso[2]),
        .tx_data(txd[7:0]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .rx_data(rxd[2]),
        .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]), .rx_overrun(rx_ovr[2]),
        .tx_underrun(tx_und[2]), .busy(busy[2]));
    spi_slave_param #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u3_dut (
        .clk(clk), .rst(rst), .sclk_in(~sclk_a), .mosi_in(mosi), .ss_in(ss[3]), .miso(miso[3]),
        .tx_data(txd[7:0]), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]), .rx_data(rxd[3]),
        .rx_valid(rx_valid[3]), .rx_ready(rx_ready[3]), .rx_overrun(rx_ovr[3]),
        .tx_underrun(tx_und[3]), .busy(busy[3]));
    spi_slave_param #(.WIDTH(12), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u4_dut (
        .clk(clk), .rst(rst), .sclk_in(sclk_a), .mosi_in(mosi), .ss_in(ss[4]), .miso(miso[4]),
        .tx_data(txd), .tx_valid(tx_valid[4]), .tx_ready(tx_ready[4]), .rx_data(rxd12),
        .rx_valid(rx_valid[4]), .rx_ready(rx_ready[4]), .rx_overrun(rx_ovr[4]),
        .tx_underrun(tx_und[4]), .busy(busy[4]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [11:0] v);
        txd = v;
        tx_valid[d] = 1'b1;
        @(negedge clk);
        tx_valid[d] = 1'b0;
    endtask

    task automatic consume(input int d);
        rx_ready[d] = 1'b1;
        @(negedge clk);
        rx_ready[d] = 1'b0;
    endtask

    // Master: n bits of mo MSB first; captures miso at each master sample edge.
    // CPOL=1 instances see the inverted sclk, so the leading edge is always sclk_a rising.
    task automatic xfer(input int d, input int n, input logic [31:0] mo, output logic [31:0] got);
        logic cpha;
        cpha = (d == 1) || (d == 3);
        got = '0;
        @(negedge clk);
        ss[d] = 1'b0;
        if (!cpha)
            mosi = mo[n-1];
        repeat (H) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            if (cpha) begin
                sclk_a = 1'b1;
                mosi = mo[i];
                repeat (H) @(negedge clk);
                got[i] = miso[d];
                sclk_a = 1'b0;
                last_samp = cyc;
                repeat (H) @(negedge clk);
            end else begin
                got[i] = miso[d];
                sclk_a = 1'b1;
                last_samp = cyc;
                repeat (H) @(negedge clk);
                sclk_a = 1'b0;
                if (i > 0)
                    mosi = mo[i-1];
                repeat (H) @(negedge clk);
            end
        end
        ss[d] = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 5; d++) begin
            check($sformatf("rst_miso%0d", d), miso[d], 1'b0);
            check($sformatf("rst_txready%0d", d), tx_ready[d], 1'b1);
            check($sformatf("rst_rxvalid%0d", d), rx_valid[d], 1'b0);
            check($sformatf("rst_busy%0d", d), busy[d], 1'b0);
        end
        check("rst_rxdata0", rxd[0], 8'h00);

        // T1: mode 0
        push(0, 12'h0A5);
        check("t1_txready", tx_ready[0], 1'b0);
        u0 = n_und[0];
        xfer(0, 8, 32'h3C, mi);
        check("t1_miso", mi, 32'hA5);
        check("t1_rxdata", rxd[0], 8'h3C);
        check("t1_rxvalid", rx_valid[0], 1'b1);
        check("t1_nrise", n_rise[0], 1);
        check("t1_latency", rise_cyc[0] - last_samp, 4);
        check("t1_busy", busy[0], 1'b0);
        check("t1_tail_underrun", n_und[0] - u0, 1);
        check("t1_overrun", n_ovr[0], 0);
        consume(0);
        check("t1_consumed", rx_valid[0], 1'b0);

        // T2: modes 1..3
        for (int d = 1; d < 4; d++) begin
            push(d, 12'h0A5);
            r0 = n_rise[d];
            xfer(d, 8, 32'h3C, mi);
            check($sformatf("t2_miso_m%0d", d), mi, 32'hA5);
            check($sformatf("t2_rxdata_m%0d", d), rxd[d], 8'h3C);
            check($sformatf("t2_nrise_m%0d", d), n_rise[d] - r0, 1);
            check($sformatf("t2_latency_m%0d", d), rise_cyc[d] - last_samp, 4);
            consume(d);
        end

        // T3: two words in one frame, rx_ready held low
        push(0, 12'h011);
        r0 = n_rise[0];
        u0 = n_und[0];
        o0 = n_ovr[0];
        fork
            xfer(0, 16, 32'h5AC3, mi);
            begin
                repeat (30) @(negedge clk);
                push(0, 12'h022);
                for (int k = 0; k < 300 && !rx_valid[0]; k++)
                    @(negedge clk);
                check("t3_first_word", rxd[0], 8'h5A);
            end
        join
        check("t3_miso", mi, 32'h1122);
        check("t3_rxdata", rxd[0], 8'hC3);
        check("t3_overrun", n_ovr[0] - o0, 1);
        check("t3_nrise", n_rise[0] - r0, 1);
        check("t3_tail_underrun", n_und[0] - u0, 1);
        consume(0);

        // T4: nothing queued
        u0 = n_und[0];
        r0 = n_rise[0];
        xfer(0, 8, 32'h69, mi);
        check("t4_miso", mi, 32'h0);
        check("t4_underrun", n_und[0] - u0, 2);
        check("t4_rxdata", rxd[0], 8'h69);
        check("t4_nrise", n_rise[0] - r0, 1);
        consume(0);

        // T5: abort after 5 bits, word queued mid-frame must survive
        r0 = n_rise[0];
        fork
            xfer(0, 5, 32'h1F, mi);
            begin
                repeat (30) @(negedge clk);
                push(0, 12'h0C6);
            end
        join
        check("t5_no_rxvalid", n_rise[0] - r0, 0);
        check("t5_busy", busy[0], 1'b0);
        check("t5_miso", miso[0], 1'b0);
        check("t5_hold_kept", tx_ready[0], 1'b0);
        xfer(0, 8, 32'h96, mi);
        check("t5_miso_next", mi, 32'hC6);
        check("t5_rxdata", rxd[0], 8'h96);
        check("t5_nrise", n_rise[0] - r0, 1);

        // T6: reset mid-word (rx_valid still set from T5)
        push(0, 12'h0FF);
        fork
            xfer(0, 8, 32'hFF, mi);
            begin
                repeat (30) @(negedge clk);
                push(0, 12'h077);
                repeat (10) @(negedge clk);
                check("t6_pre_miso", miso[0], 1'b1);
                check("t6_pre_txready", tx_ready[0], 1'b0);
                rst = 1'b1;
                #1;
                check("t6_rst_miso", miso[0], 1'b0);
                check("t6_rst_txready", tx_ready[0], 1'b1);
                check("t6_rst_rxvalid", rx_valid[0], 1'b0);
                check("t6_rst_rxdata", rxd[0], 8'h00);
                check("t6_rst_busy", busy[0], 1'b0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        r0 = n_rise[0];
        check("t6_no_resume_rxvalid", rx_valid[0], 1'b0);
        check("t6_no_resume_busy", busy[0], 1'b0);
        push(0, 12'h0A5);
        xfer(0, 8, 32'h3C, mi);
        check("t6_miso", mi, 32'hA5);
        check("t6_rxdata", rxd[0], 8'h3C);
        check("t6_nrise", n_rise[0] - r0, 1);

        // WIDTH=12 rerun
        push(4, 12'hA53);
        r0 = n_rise[4];
        xfer(4, 12, 32'h3C6, mi);
        check("w12_miso", mi, 32'hA53);
        check("w12_rxdata", rxd12, 12'h3C6);
        check("w12_nrise", n_rise[4] - r0, 1);
        check("w12_latency", rise_cyc[4] - last_samp, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
